vending_controller: RTL and testbench



---
 rtl/vending_controller_pkg.sv | 42 ++++
 rtl/vending_controller_price_table.sv | 26 ++
 rtl/vending_controller.sv | 173 +++++++++++++++++
 tb/tb_vending_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_controller_pkg.sv
// Shared definitions for the vending controller: state encoding, product codes
// with their prices, legal coin values and the default credit ceiling.
package vending_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PAYING   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_e;

    localparam int CREDIT_MAX_DEFAULT = 15;

    localparam logic [2:0] COIN_1 = 3'd1;
    localparam logic [2:0] COIN_2 = 3'd2;
    localparam logic [2:0] COIN_5 = 3'd5;

    localparam logic [3:0] CODE_P0 = 4'b0000;
    localparam logic [3:0] CODE_P1 = 4'b0100;
    localparam logic [3:0] CODE_P2 = 4'b0101;
    localparam logic [3:0] CODE_P3 = 4'b1000;
    localparam logic [3:0] CODE_P4 = 4'b1001;
    localparam logic [3:0] CODE_P5 = 4'b1010;
    localparam logic [3:0] CODE_P6 = 4'b1011;
    localparam logic [3:0] CODE_P7 = 4'b1100;
    localparam logic [3:0] CODE_P8 = 4'b1101;

    localparam logic [3:0] PRICE_P0 = 4'd4;
    localparam logic [3:0] PRICE_P1 = 4'd8;
    localparam logic [3:0] PRICE_P2 = 4'd2;
    localparam logic [3:0] PRICE_P3 = 4'd2;
    localparam logic [3:0] PRICE_P4 = 4'd5;
    localparam logic [3:0] PRICE_P5 = 4'd7;
    localparam logic [3:0] PRICE_P6 = 4'd6;
    localparam logic [3:0] PRICE_P7 = 4'd4;
    localparam logic [3:0] PRICE_P8 = 4'd7;

    function automatic logic coin_is_legal(input logic [2:0] value);
        return (value == COIN_1) || (value == COIN_2) || (value == COIN_5);
    endfunction

endpackage

// File: rtl/vending_controller_price_table.sv
// Combinational keypad code to price lookup; a price of zero marks an empty slot.
module vending_controller_price_table
    import vending_controller_pkg::*;
(
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [3:0] price
);

    // Map {row,col} onto the product price list
    always_comb begin
        case ({row, col})
            CODE_P0: price = PRICE_P0;
            CODE_P1: price = PRICE_P1;
            CODE_P2: price = PRICE_P2;
            CODE_P3: price = PRICE_P3;
            CODE_P4: price = PRICE_P4;
            CODE_P5: price = PRICE_P5;
            CODE_P6: price = PRICE_P6;
            CODE_P7: price = PRICE_P7;
            CODE_P8: price = PRICE_P8;
            default: price = 4'd0;
        endcase
    end

endmodule

// File: rtl/vending_controller.sv
// Vending sequencer: selection, coin collection, dispense and unit-by-unit change.
// Every output comes straight from a flop.
module vending_controller
    import vending_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CREDIT_MAX     = CREDIT_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_valid,
    input  logic [1:0] row,
    input  logic [1:0] col,
    input  logic       coin_valid,
    input  logic [2:0] coin_value,
    input  logic       cancel,
    output logic [3:0] price,
    output logic [4:0] credit,
    output logic       invalid_sel,
    output logic       coin_reject,
    output logic       dispense,
    output logic [3:0] dispense_id,
    output logic       change_pulse,
    output logic       busy
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [4:0]         credit_q, credit_d;
    logic [3:0]         price_q, price_d;
    logic [3:0]         id_q, id_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               invalid_q, invalid_d;
    logic               reject_q, reject_d;
    logic               dispense_q, dispense_d;
    logic               change_q, change_d;
    logic               busy_q, busy_d;

    logic [3:0] tbl_price_s;
    logic [5:0] coin_sum_s;
    logic       coin_accept_s;
    logic       paid_s;
    logic       timer_expired_s;

    vending_controller_price_table price_table (
        .row   (row),
        .col   (col),
        .price (tbl_price_s)
    );

    // Six-bit sum so an overflowing coin is still compared correctly
    assign coin_sum_s      = {1'b0, credit_q} + {3'b000, coin_value};
    assign coin_accept_s   = (state_q == ST_PAYING) && coin_valid && !cancel &&
                             coin_is_legal(coin_value) && (coin_sum_s <= 6'(CREDIT_MAX));
    assign paid_s          = coin_sum_s >= {2'b00, price_q};
    assign timer_expired_s = timer_q == TIMER_W'(TIMEOUT_CYCLES - 1);

    // State and output register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            credit_q   <= 5'd0;
            price_q    <= 4'd0;
            id_q       <= 4'd0;
            timer_q    <= {TIMER_W{1'b0}};
            invalid_q  <= 1'b0;
            reject_q   <= 1'b0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            price_q    <= price_d;
            id_q       <= id_d;
            timer_q    <= timer_d;
            invalid_q  <= invalid_d;
            reject_q   <= reject_d;
            dispense_q <= dispense_d;
            change_q   <= change_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state decision; cancel outranks coins, an accepted coin outranks timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid && (tbl_price_s != 4'd0)) state_d = ST_PAYING;
                else                                    state_d = ST_IDLE;
            end
            ST_PAYING: begin
                if (cancel || (!coin_accept_s && timer_expired_s)) begin
                    state_d = (credit_q == 5'd0) ? ST_IDLE : ST_CHANGE;
                end else if (coin_accept_s) begin
                    state_d = paid_s ? ST_DISPENSE : ST_PAYING;
                end else begin
                    state_d = ST_PAYING;
                end
            end
            ST_DISPENSE: state_d = (credit_q == {1'b0, price_q}) ? ST_IDLE : ST_CHANGE;
            ST_CHANGE:   state_d = (credit_q <= 5'd1) ? ST_IDLE : ST_CHANGE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered output values for the coming cycle
    always_comb begin
        credit_d  = credit_q;
        price_d   = price_q;
        id_d      = id_q;
        timer_d   = timer_q;
        invalid_d = 1'b0;
        reject_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                credit_d = 5'd0;
                timer_d  = {TIMER_W{1'b0}};
                reject_d = coin_valid;
                if (sel_valid && (tbl_price_s == 4'd0)) begin
                    invalid_d = 1'b1;
                    price_d   = 4'd0;
                end else if (sel_valid) begin
                    price_d = tbl_price_s;
                    id_d    = {row, col};
                end else begin
                    price_d = 4'd0;
                end
            end
            ST_PAYING: begin
                price_d = (state_d == ST_IDLE) ? 4'd0 : price_q;
                if (coin_accept_s) begin
                    credit_d = coin_sum_s[4:0];
                    timer_d  = {TIMER_W{1'b0}};
                end else begin
                    reject_d = coin_valid;
                    if (!timer_expired_s) timer_d = timer_q + TIMER_W'(1);
                    else                  timer_d = timer_q;
                end
            end
            ST_DISPENSE: begin
                reject_d = coin_valid;
                credit_d = credit_q - {1'b0, price_q};
                price_d  = (state_d == ST_IDLE) ? 4'd0 : price_q;
            end
            ST_CHANGE: begin
                reject_d = coin_valid;
                credit_d = credit_q - 5'd1;
                price_d  = (state_d == ST_IDLE) ? 4'd0 : price_q;
            end
            default: begin
                credit_d = 5'd0;
                price_d  = 4'd0;
                timer_d  = {TIMER_W{1'b0}};
            end
        endcase
        dispense_d = (state_d == ST_DISPENSE);
        change_d   = (state_d == ST_CHANGE);
        busy_d     = (state_d != ST_IDLE);
    end

    assign price        = price_q;
    assign credit       = credit_q;
    assign invalid_sel  = invalid_q;
    assign coin_reject  = reject_q;
    assign dispense     = dispense_q;
    assign dispense_id  = id_q;
    assign change_pulse = change_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed vector table, hand-written timeout and
// reset sequences, then random traffic against a transaction-level reference model.
module tb_vending_controller;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel_valid, coin_valid, cancel;
    logic [1:0] row, col;
    logic [2:0] coin_value;
    logic [3:0] price, dispense_id;
    logic [4:0] credit;
    logic       invalid_sel, coin_reject, dispense, change_pulse, busy;

    vending_controller #(.TIMEOUT_CYCLES(T), .CREDIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .sel_valid(sel_valid), .row(row), .col(col),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .price(price), .credit(credit), .invalid_sel(invalid_sel),
        .coin_reject(coin_reject), .dispense(dispense), .dispense_id(dispense_id),
        .change_pulse(change_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a pending purchase is described by its price (0 = none),
    // the money held, quiet cycles seen and the amount still owed back.
    int price_of[16] = '{4, 0, 0, 0, 8, 2, 0, 0, 2, 5, 7, 6, 4, 7, 0, 0};
    int m_price, m_credit, m_id, m_quiet;
    bit m_disp, m_chg, m_inv, m_rej;

    typedef struct {
        bit s; logic [3:0] code; bit c; logic [2:0] v; bit k;
        int e_price, e_credit, e_id;
        bit e_inv, e_rej, e_disp, e_chg, e_busy;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit s, logic [3:0] code, bit c, logic [2:0] v, bit k,
                                int ep, int ec, int eid, bit ei, bit er, bit ed, bit ech, bit eb);
        vec_t r;
        r.s = s; r.code = code; r.c = c; r.v = v; r.k = k;
        r.e_price = ep; r.e_credit = ec; r.e_id = eid;
        r.e_inv = ei; r.e_rej = er; r.e_disp = ed; r.e_chg = ech; r.e_busy = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_price = 0; m_credit = 0; m_id = 0; m_quiet = 0;
        m_disp = 0; m_chg = 0; m_inv = 0; m_rej = 0;
    endtask

    task automatic model_step(input bit s, input logic [3:0] code, input bit c,
                              input logic [2:0] v, input bit k);
        bit was_disp = m_disp;
        bit legal    = (v == 3'd1) || (v == 3'd2) || (v == 3'd5);
        m_inv = 0; m_rej = 0; m_disp = 0;
        if (m_price == 0) begin
            m_rej = c;
            if (s && price_of[code] == 0) m_inv = 1;
            else if (s) begin m_price = price_of[code]; m_id = int'(code); m_quiet = 0; end
        end else if (was_disp) begin
            m_rej = c;
            m_credit -= m_price;
            if (m_credit == 0) m_price = 0; else m_chg = 1;
        end else if (m_chg) begin
            m_rej = c;
            m_credit -= 1;
            if (m_credit == 0) begin m_price = 0; m_chg = 0; end
        end else if (k) begin
            m_rej = c;
            if (m_credit == 0) m_price = 0; else m_chg = 1;
        end else if (c && legal && (m_credit + int'(v) <= 15)) begin
            m_credit += int'(v);
            m_quiet = 0;
            if (m_credit >= m_price) m_disp = 1;
        end else begin
            m_rej = c;
            m_quiet++;
            if (m_quiet == T) begin
                if (m_credit == 0) m_price = 0; else m_chg = 1;
            end
        end
    endtask

    task automatic tick(input bit s, input logic [3:0] code, input bit c,
                        input logic [2:0] v, input bit k);
        sel_valid = s; {row, col} = code; coin_valid = c; coin_value = v; cancel = k;
        @(posedge clk);
        model_step(s, code, c, v, k);
        #1;
        sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".price"},  8'(price),        8'(m_price));
        check({tag, ".credit"}, 8'(credit),       8'(m_credit));
        check({tag, ".id"},     8'(dispense_id),  8'(m_id));
        check({tag, ".inv"},    8'(invalid_sel),  8'(m_inv));
        check({tag, ".rej"},    8'(coin_reject),  8'(m_rej));
        check({tag, ".disp"},   8'(dispense),     8'(m_disp));
        check({tag, ".chg"},    8'(change_pulse), 8'(m_chg));
        check({tag, ".busy"},   8'(busy),         8'(m_price != 0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".price"},  8'(price), 8'd0);
        check({tag, ".credit"}, 8'(credit), 8'd0);
        check({tag, ".id"},     8'(dispense_id), 8'd0);
        check({tag, ".pulses"}, 8'({invalid_sel, coin_reject, dispense, change_pulse}), 8'd0);
        check({tag, ".busy"},   8'(busy), 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset = 1'b1; sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
        row = 2'd0; col = 2'd0; coin_value = 3'd0;
        model_reset();
        #2;
        check_all_zero("rst");
        do_reset();

        // Directed vectors: inputs for one cycle, outputs expected after that edge
        vecs.push_back(mk(1, 4'b1001, 0, 0, 0, 5, 0, 9, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 5, 0, 5, 5, 9, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 0, 0, 8, 0, 4, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 5, 0, 8, 5, 4, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 5, 0, 8, 10, 4, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 8, 2, 4, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 8, 1, 4, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0110, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1100, 0, 0, 0, 4, 0, 12, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 3, 0, 4, 0, 12, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 4'b0000, 1, 1, 0, 4, 1, 12, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 4, 1, 12, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1010, 0, 0, 0, 7, 0, 10, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 2, 0, 7, 2, 10, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 5, 1, 7, 2, 10, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 7, 1, 10, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0, 10, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 0, 0, 8, 0, 4, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 5, 0, 8, 5, 4, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 5, 0, 8, 10, 4, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 1, 5, 0, 8, 2, 4, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 8, 1, 4, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            tick(vecs[i].s, vecs[i].code, vecs[i].c, vecs[i].v, vecs[i].k);
            check({t, ".price"},  8'(price),        8'(vecs[i].e_price));
            check({t, ".credit"}, 8'(credit),       8'(vecs[i].e_credit));
            check({t, ".id"},     8'(dispense_id),  8'(vecs[i].e_id));
            check({t, ".inv"},    8'(invalid_sel),  8'(vecs[i].e_inv));
            check({t, ".rej"},    8'(coin_reject),  8'(vecs[i].e_rej));
            check({t, ".disp"},   8'(dispense),     8'(vecs[i].e_disp));
            check({t, ".chg"},    8'(change_pulse), 8'(vecs[i].e_chg));
            check({t, ".busy"},   8'(busy),         8'(vecs[i].e_busy));
        end

        // Timeout with credit 1: one refund pulse on the eighth quiet cycle
        tick(1, 4'b0000, 0, 0, 0);
        tick(0, 4'b0000, 1, 1, 0);
        check("to1.credit", 8'(credit), 8'd1);
        pulses = 0;
        for (int i = 1; i <= T; i++) begin
            tick(0, 4'b0000, 0, 0, 0);
            pulses += int'(change_pulse);
            check($sformatf("to1.q%0d.chg", i), 8'(change_pulse), 8'(i == T));
            check($sformatf("to1.q%0d.busy", i), 8'(busy), 8'd1);
        end
        tick(0, 4'b0000, 0, 0, 0);
        check("to1.end.busy", 8'(busy), 8'd0);
        check("to1.end.price", 8'(price), 8'd0);
        check("to1.pulses", 8'(pulses), 8'd1);

        // Timeout with no credit: straight back to idle, no pulses
        tick(1, 4'b1000, 0, 0, 0);
        for (int i = 1; i <= T; i++) begin
            tick(0, 4'b0000, 0, 0, 0);
            check($sformatf("to0.q%0d.busy", i), 8'(busy), 8'(i != T));
            check($sformatf("to0.q%0d.chg", i), 8'(change_pulse), 8'd0);
        end

        // Coin arriving on the expiry cycle is accepted and restarts the timer
        tick(1, 4'b1001, 0, 0, 0);
        repeat (T - 1) tick(0, 4'b0000, 0, 0, 0);
        tick(0, 4'b0000, 1, 1, 0);
        check("toc.credit", 8'(credit), 8'd1);
        check("toc.chg", 8'(change_pulse), 8'd0);
        check("toc.rej", 8'(coin_reject), 8'd0);
        for (int i = 1; i <= T; i++) begin
            tick(0, 4'b0000, 0, 0, 0);
            check($sformatf("toc.q%0d.chg", i), 8'(change_pulse), 8'(i == T));
        end
        tick(0, 4'b0000, 0, 0, 0);

        // Reset during change with credit 3
        tick(1, 4'b0100, 0, 0, 0);
        tick(0, 4'b0000, 1, 1, 0);
        tick(0, 4'b0000, 1, 2, 0);
        tick(0, 4'b0000, 0, 0, 1);
        check("rc.chg", 8'(change_pulse), 8'd1);
        check("rc.credit", 8'(credit), 8'd3);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("rc.async");
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(0, 4'b0000, 0, 0, 0);
            check_all_zero($sformatf("rc.after%0d", i));
        end

        // Random traffic against the reference model
        for (int i = 0; i < 2500; i++) begin
            bit s, c, k;
            logic [3:0] code;
            logic [2:0] v;
            int pick;
            s    = ($urandom_range(0, 9) == 0);
            code = 4'($urandom_range(0, 15));
            c    = ($urandom_range(0, 3) == 0);
            pick = $urandom_range(0, 3);
            if (pick == 0)      v = 3'($urandom_range(0, 7));
            else if (pick == 1) v = 3'd1;
            else if (pick == 2) v = 3'd2;
            else                v = 3'd5;
            k = ($urandom_range(0, 29) == 0);
            tick(s, code, c, v, k);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
